div_mae_monitor: RTL and testbench

Sequential error monitor that sits directly downstream of the 16/8 approximate array divider. Each operand pair (n, d) is captured together with the divider's approximate quotient and remainder. The monitor recomputes the exact result with an 8-iteration restoring divider, then accumulates quotient absolute error over a fixed window. At the end of each window it publishes MAE, maximum error and mismatch statistics, for the pwr-mae characterisation flow.

---
 rtl/div_mae_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_div_mae_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_mae_monitor.sv
`timescale 1ns / 1ps
// div_mae_monitor
// Error monitor placed downstream of the 16/8 approximate array divider. Each accepted
// (n, d, q_apx, r_apx) sample is re-divided exactly with an 8-iteration restoring divider.
// Quotient absolute error is accumulated over a window of 2^SAMPLES_LOG2 non-overflow
// samples. At the end of each window the MAE, the maximum error and the mismatch count
// are published.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   clr       synchronous clear of accumulators and ovf_cnt; drops any in-flight sample
//   in_valid  sample present
//   in_ready  monitor can accept a sample
//   n, d      dividend / divisor given to the divider
//   q_apx     approximate quotient
//   r_apx     approximate remainder
//   mae       floor(window error sum / 2^SAMPLES_LOG2), published
//   max_err   largest quotient error in the window, published
//   mism_cnt  samples with a quotient or remainder mismatch, published
//   ovf_cnt   overflow samples since reset/clr, saturating
//   done      one-cycle pulse when the published outputs update
module div_mae_monitor #(
  parameter int unsigned SAMPLES_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             n,
  input  logic [7:0]              d,
  input  logic [7:0]              q_apx,
  input  logic [7:0]              r_apx,
  output logic [7:0]              mae,
  output logic [7:0]              max_err,
  output logic [SAMPLES_LOG2:0]   mism_cnt,
  output logic [15:0]             ovf_cnt,
  output logic                    done
);

  localparam int unsigned SumW = 8 + SAMPLES_LOG2;
  localparam int unsigned CntW = SAMPLES_LOG2 + 1;
  localparam logic [CntW-1:0] WinLen = CntW'(1) << SAMPLES_LOG2;

  typedef enum logic [1:0] {StIdle, StDiv, StAcc} state_e;

  state_e            state_q, state_d;
  logic              rst_ok_q;
  logic [7:0]        nlo_q, nlo_d;     // remaining dividend bits, consumed MSB first
  logic [7:0]        d_q, d_d;
  logic [7:0]        qa_q, qa_d;
  logic [7:0]        ra_q, ra_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        quo_q, quo_d;
  logic [2:0]        it_q, it_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [7:0]        max_q, max_d;
  logic [CntW-1:0]   mism_q, mism_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        mae_q, mae_d;
  logic [7:0]        max_err_q, max_err_d;
  logic [CntW-1:0]   mism_cnt_q, mism_cnt_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              is_ovf;
  logic [8:0]        pr;
  logic              ge;
  logic [7:0]        err;
  logic              mism_hit;
  logic [SumW-1:0]   sum_new;
  logic [7:0]        max_new;
  logic [CntW-1:0]   mism_new;
  logic [CntW-1:0]   cnt_new;

  // rst_ok_q holds in_ready low until the first edge that sees rst_n released.
  assign in_ready = (state_q == StIdle) && !clr && rst_ok_q;
  assign xfer     = in_valid && in_ready;
  assign is_ovf   = (d == 8'd0) || (n[15:8] >= d);

  assign pr       = {rem_q, nlo_q[7]};
  assign ge       = pr >= {1'b0, d_q};

  assign err      = (qa_q > quo_q) ? (qa_q - quo_q) : (quo_q - qa_q);
  assign mism_hit = (qa_q != quo_q) || (ra_q != rem_q);
  assign sum_new  = sum_q + SumW'(err);
  assign max_new  = (err > max_q) ? err : max_q;
  assign mism_new = mism_q + CntW'(mism_hit);
  assign cnt_new  = cnt_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    nlo_d      = nlo_q;
    d_d        = d_q;
    qa_d       = qa_q;
    ra_d       = ra_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    it_d       = it_q;
    ovf_flag_d = ovf_flag_q;
    sum_d      = sum_q;
    max_d      = max_q;
    mism_d     = mism_q;
    cnt_d      = cnt_q;
    mae_d      = mae_q;
    max_err_d  = max_err_q;
    mism_cnt_d = mism_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          nlo_d      = n[7:0];
          rem_d      = n[15:8];
          d_d        = d;
          qa_d       = q_apx;
          ra_d       = r_apx;
          quo_d      = 8'd0;
          it_d       = 3'd0;
          ovf_flag_d = is_ovf;
          state_d    = is_ovf ? StAcc : StDiv;
        end
      end
      StDiv: begin
        // pr < 2*d, so the restored or reduced remainder always fits in 8 bits.
        rem_d = 8'(ge ? (pr - {1'b0, d_q}) : pr);
        quo_d = {quo_q[6:0], ge};
        nlo_d = {nlo_q[6:0], 1'b0};
        it_d  = it_q + 3'd1;
        if (it_q == 3'd7) state_d = StAcc;
      end
      StAcc: begin
        state_d = StIdle;
        if (ovf_flag_q) begin
          if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end else if (cnt_new == WinLen) begin
          mae_d      = sum_new[SAMPLES_LOG2 +: 8];
          max_err_d  = max_new;
          mism_cnt_d = mism_new;
          done_d     = 1'b1;
          sum_d      = '0;
          max_d      = '0;
          mism_d     = '0;
          cnt_d      = '0;
        end else begin
          sum_d  = sum_new;
          max_d  = max_new;
          mism_d = mism_new;
          cnt_d  = cnt_new;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d   = StIdle;
      sum_d     = '0;
      max_d     = '0;
      mism_d    = '0;
      cnt_d     = '0;
      ovf_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rst_ok_q   <= 1'b0;
      nlo_q      <= '0;
      d_q        <= '0;
      qa_q       <= '0;
      ra_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      it_q       <= '0;
      ovf_flag_q <= 1'b0;
      sum_q      <= '0;
      max_q      <= '0;
      mism_q     <= '0;
      cnt_q      <= '0;
      mae_q      <= '0;
      max_err_q  <= '0;
      mism_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_ok_q   <= 1'b1;
      nlo_q      <= nlo_d;
      d_q        <= d_d;
      qa_q       <= qa_d;
      ra_q       <= ra_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      it_q       <= it_d;
      ovf_flag_q <= ovf_flag_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      mism_q     <= mism_d;
      cnt_q      <= cnt_d;
      mae_q      <= mae_d;
      max_err_q  <= max_err_d;
      mism_cnt_q <= mism_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      done_q     <= done_d;
    end
  end

  assign mae      = mae_q;
  assign max_err  = max_err_q;
  assign mism_cnt = mism_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_div_mae_monitor.sv
`timescale 1ns / 1ps
// Bench for div_mae_monitor with a 4-sample window. Stimulus pushes hand-computed window
// results into a queue; an independent monitor pops and compares on every done pulse.
module tb_div_mae_monitor;
  localparam int unsigned SL = 2;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, in_ready, done;
  logic [15:0]   n, ovf_cnt;
  logic [7:0]    d, q_apx, r_apx, mae, max_err;
  logic [SL:0]   mism_cnt;

  div_mae_monitor #(.SAMPLES_LOG2(SL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .mae(mae), .max_err(max_err),
    .mism_cnt(mism_cnt), .ovf_cnt(ovf_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  mae;
    logic [7:0]  mx;
    logic [SL:0] mm;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected window result.
  always @(negedge clk) begin
    if (rst_n && done) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("mae", mae, e.mae);
        chk("max_err", max_err, e.mx);
        chk("mism_cnt", mism_cnt, e.mm);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                      input logic [7:0] ra, output int xc);
    int w;
    w = 0;
    n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      xc = -1;
      return;
    end
    xc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_busy", in_ready, 0);
  endtask

  // Sends one sample; on the window's last sample, queues the expected publication.
  task automatic samp(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                      input logic [7:0] ra, input bit last, input logic [7:0] em,
                      input logic [7:0] ex, input logic [SL:0] emm);
    int xc;
    send(nn, dd, qa, ra, xc);
    if (last && xc >= 0) sb.push_back('{em, ex, emm, xc + 9});
  endtask

  initial begin
    int xc;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    n = '0; d = '0; q_apx = '0; r_apx = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_mae", mae, 0);
    chk("rst_max", max_err, 0);
    chk("rst_mism", mism_cnt, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    #1 chk("ready_at_release", in_ready, 0);
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);

    // Window A: exact matches (100/7 = 14 r 2)
    for (int i = 0; i < 4; i++) samp(16'd100, 8'd7, 8'd14, 8'd2, i == 3, 8'd0, 8'd0, 3'd0);

    // Window B: errors +3, -5 | two overflows | 0, +1 -> sum 9, mae 2, max 5, mism 3
    samp(16'd100, 8'd7, 8'd17, 8'd2, 1'b0, 8'd0, 8'd0, 3'd0);
    samp(16'd100, 8'd7, 8'd9,  8'd2, 1'b0, 8'd0, 8'd0, 3'd0);
    send(16'h1234, 8'h00, 8'd0, 8'd0, xc);
    send(16'h0900, 8'h09, 8'd0, 8'd0, xc);
    @(negedge clk);
    chk("ovf_cnt_2", ovf_cnt, 2);
    samp(16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8'd0, 8'd0, 3'd0);
    samp(16'd100, 8'd7, 8'd15, 8'd2, 1'b1, 8'd2, 8'd5, 3'd3);

    // Window C: remainder-only mismatch (255/16 = 15 r 15) plus 3 exact
    samp(16'h00FF, 8'h10, 8'd15, 8'd0, 1'b0, 8'd0, 8'd0, 3'd0);
    for (int i = 0; i < 3; i++) samp(16'd100, 8'd7, 8'd14, 8'd2, i == 2, 8'd0, 8'd0, 3'd1);

    // Window D: 4660/64=72r52 (err 2), 65025/255=255r0 (err 5), 32767/128=255r127 (exact),
    // 5/1=5r0 (err 5) -> sum 12, mae 3, max 5, mism 3
    samp(16'h1234, 8'h40, 8'd70,  8'd52,  1'b0, 8'd0, 8'd0, 3'd0);
    samp(16'hFE01, 8'hFF, 8'd250, 8'd0,   1'b0, 8'd0, 8'd0, 3'd0);
    samp(16'h7FFF, 8'h80, 8'd255, 8'd127, 1'b0, 8'd0, 8'd0, 3'd0);
    samp(16'h0005, 8'h01, 8'd0,   8'd0,   1'b1, 8'd3, 8'd5, 3'd3);

    // clr mid-DIV of the 4th sample of a window (3 prior samples with err 3)
    for (int i = 0; i < 3; i++) samp(16'd100, 8'd7, 8'd17, 8'd2, 1'b0, 8'd0, 8'd0, 3'd0);
    send(16'd100, 8'd7, 8'd17, 8'd2, xc);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_ready", in_ready, 1);
    chk("clr_mae_kept", mae, 3);
    chk("clr_max_kept", max_err, 5);
    chk("clr_mism_kept", mism_cnt, 3);
    chk("clr_ovf_zero", ovf_cnt, 0);
    @(negedge clk);
    // Window E: err 1 each -> sum 4, mae 1, max 1, mism 4
    for (int i = 0; i < 4; i++) samp(16'd100, 8'd7, 8'd15, 8'd2, i == 3, 8'd1, 8'd1, 3'd4);

    // Reset mid-DIV with in_valid held high across release
    send(16'h0000, 8'h00, 8'd0, 8'd0, xc);
    send(16'd100, 8'd7, 8'd14, 8'd2, xc);
    repeat (2) @(negedge clk);
    chk("pre_rst_ovf", ovf_cnt, 1);
    rst_n = 1'b0;
    n = 16'd100; d = 8'd7; q_apx = 8'd14; r_apx = 8'd2; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_mae", mae, 0);
    chk("mid_rst_max", max_err, 0);
    chk("mid_rst_mism", mism_cnt, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_ready0", in_ready, 0);
    @(negedge clk);
    chk("mid_rel_ready1", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_taken", in_ready, 0);
    // Held sample exact, then 3 with err 2 -> sum 6, mae 1, max 2, mism 3
    for (int i = 0; i < 3; i++) samp(16'd100, 8'd7, 8'd16, 8'd2, i == 2, 8'd1, 8'd2, 3'd3);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
